// File: rtl/rename_reg_file_pkg.sv
// Shared sizing for the rename register file, reservation stations and ROB.
package rename_reg_file_pkg;

    localparam int unsigned RRF_XLEN  = 32;
    localparam int unsigned RRF_NREG  = 32;
    localparam int unsigned RRF_IDX_W = $clog2(RRF_NREG);
    localparam int unsigned RRF_TAG_W = 4;
    localparam int unsigned RRF_NRP   = 2;

    localparam logic [RRF_IDX_W-1:0] RRF_ZERO_REG = '0;

    // Architectural register zero is hardwired; any access to it is inert.
    function automatic logic rrf_is_zero(input logic [RRF_IDX_W-1:0] idx);
        return idx == RRF_ZERO_REG;
    endfunction

endpackage

// File: rtl/rrf_read_port.sv
// One issue-side read port: register select, x0 forcing and commit bypass.
module rrf_read_port
    import rename_reg_file_pkg::*;
#(
    parameter  int unsigned XLEN   = RRF_XLEN,
    parameter  int unsigned NREG   = RRF_NREG,
    parameter  int unsigned TAG_W  = RRF_TAG_W,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned IDX_W  = $clog2(NREG)
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]  value_i [NREG],
    input  logic [NREG-1:0]  busy_i,
    input  logic [TAG_W-1:0] tag_i   [NREG],
    input  logic             rdy_i,
    input  logic             cm_valid_i,
    input  logic [IDX_W-1:0] cm_rd_i,
    input  logic [TAG_W-1:0] cm_tag_i,
    input  logic [XLEN-1:0]  cm_value_i,
    output logic [XLEN-1:0]  value_c_o,
    output logic             busy_c_o,
    output logic [TAG_W-1:0] tag_c_o
);

    logic hit_c;
    logic is_zero_c;

    assign hit_c     = (BYPASS != 0) && rdy_i && cm_valid_i && (cm_rd_i == idx_i);
    assign is_zero_c = (idx_i == IDX_W'(RRF_ZERO_REG));

    always_comb begin
        value_c_o = value_i[idx_i];
        busy_c_o  = busy_i[idx_i];
        tag_c_o   = tag_i[idx_i];
        // A commit landing this cycle resolves the producer only if its tag is still current.
        if (hit_c) begin
            value_c_o = cm_value_i;
            if (busy_i[idx_i] && (tag_i[idx_i] == cm_tag_i)) begin
                busy_c_o = 1'b0;
            end
        end
        if (is_zero_c) begin
            value_c_o = '0;
            busy_c_o  = 1'b0;
            tag_c_o   = '0;
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tracking.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter  int unsigned XLEN   = RRF_XLEN,
    parameter  int unsigned NREG   = RRF_NREG,
    parameter  int unsigned TAG_W  = RRF_TAG_W,
    parameter  int unsigned NRP    = RRF_NRP,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned IDX_W  = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic [NRP*IDX_W-1:0]   rd_idx,
    output logic [NRP*XLEN-1:0]    rd_value,
    output logic [NRP-1:0]         rd_busy,
    output logic [NRP*TAG_W-1:0]   rd_tag,
    input  logic                   iss_valid,
    input  logic [IDX_W-1:0]       iss_rd,
    input  logic [TAG_W-1:0]       iss_tag,
    input  logic                   cm_valid,
    input  logic [IDX_W-1:0]       cm_rd,
    input  logic [TAG_W-1:0]       cm_tag,
    input  logic [XLEN-1:0]        cm_value,
    input  logic                   flush,
    output logic [NREG-1:0]        busy_mask
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];

    logic cm_en_c;
    logic iss_en_c;

    assign cm_en_c  = rdy && cm_valid && (cm_rd != IDX_W'(RRF_ZERO_REG));
    assign iss_en_c = rdy && iss_valid && !flush && (iss_rd != IDX_W'(RRF_ZERO_REG));

    // Commit first, then flush or issue; a same-register issue overrides the commit's clear.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (cm_en_c) begin
            value_d[cm_rd] = cm_value;
            if (busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag)) begin
                busy_d[cm_rd] = 1'b0;
            end
        end
        if (rdy && flush) begin
            busy_d = '0;
        end else if (iss_en_c) begin
            busy_d[iss_rd] = 1'b1;
            tag_d[iss_rd]  = iss_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    assign busy_mask = busy_q;

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        rrf_read_port #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .TAG_W  (TAG_W),
            .BYPASS (BYPASS)
        ) u_rp (
            .idx_i      (rd_idx[p*IDX_W +: IDX_W]),
            .value_i    (value_q),
            .busy_i     (busy_q),
            .tag_i      (tag_q),
            .rdy_i      (rdy),
            .cm_valid_i (cm_valid),
            .cm_rd_i    (cm_rd),
            .cm_tag_i   (cm_tag),
            .cm_value_i (cm_value),
            .value_c_o  (rd_value[p*XLEN +: XLEN]),
            .busy_c_o   (rd_busy[p]),
            .tag_c_o    (rd_tag[p*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed vector table, corner sequences, random vs reference model.
module tb_rename_reg_file;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NRP   = 2;
    localparam int unsigned IW    = 5;

    logic                 clk;
    logic                 rst;
    logic                 rdy;
    logic [NRP*IW-1:0]    rd_idx;
    logic [NRP*XLEN-1:0]  rd_value;
    logic [NRP-1:0]       rd_busy;
    logic [NRP*TAG_W-1:0] rd_tag;
    logic                 iss_valid;
    logic [IW-1:0]        iss_rd;
    logic [TAG_W-1:0]     iss_tag;
    logic                 cm_valid;
    logic [IW-1:0]        cm_rd;
    logic [TAG_W-1:0]     cm_tag;
    logic [XLEN-1:0]      cm_value;
    logic                 flush;
    logic [NREG-1:0]      busy_mask;

    rename_reg_file #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRP(NRP), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_idx(rd_idx), .rd_value(rd_value), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
        .flush(flush), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: architectural view of each register.
    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    task automatic model_reset();
        for (int r = 0; r < int'(NREG); r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
    endtask

    task automatic model_update();
        if (!rdy || !rst) return;
        if (cm_valid && cm_rd != 0) begin
            m_val[cm_rd] = cm_value;
            if (m_busy[cm_rd] && m_tag[cm_rd] == cm_tag) m_busy[cm_rd] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
        end else if (iss_valid && iss_rd != 0) begin
            m_busy[iss_rd] = 1'b1;
            m_tag[iss_rd]  = iss_tag;
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        m = '0;
        for (int r = 0; r < int'(NREG); r++) if (m_busy[r]) m = m | (NREG'(1) << r);
        return m;
    endfunction

    task automatic model_read(input logic [IW-1:0] idx, output logic [XLEN-1:0] v,
                              output logic b, output logic [TAG_W-1:0] t);
        v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
        if (cm_valid && rdy && cm_rd == idx) begin
            v = cm_value;
            if (b && t == cm_tag) b = 1'b0;
        end
        if (idx == 0) begin v = '0; b = 1'b0; t = '0; end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; iss_valid = 1'b0; iss_rd = '0; iss_tag = '0;
        cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_value = '0; flush = 1'b0;
    endtask

    typedef struct {
        logic             iv;  logic [IW-1:0] ird; logic [TAG_W-1:0] itag;
        logic             cv;  logic [IW-1:0] crd; logic [TAG_W-1:0] ctag; logic [XLEN-1:0] cval;
        logic             fl;
        logic [IW-1:0]    r0;  logic [IW-1:0] r1;
        logic [XLEN-1:0]  ev0; logic eb0; logic [TAG_W-1:0] et0;
        logic [XLEN-1:0]  ev1; logic eb1; logic [TAG_W-1:0] et1;
        logic [NREG-1:0]  emask;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] ev;
        logic eb;
        logic [TAG_W-1:0] et;
        logic [IW-1:0] ix;

        n_pass = 0; n_total = 0;
        vecs[0]  = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd5,5'd0, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd0,     32'h0};
        vecs[1]  = '{1'b1,5'd3,4'd7,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd3,5'd0, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd0,     32'h0};
        vecs[2]  = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd3,5'd3, 32'h0,1'b1,4'd7,     32'h0,1'b1,4'd7,     32'h8};
        vecs[3]  = '{1'b0,5'd0,4'd0,  1'b1,5'd3,4'd7,32'h1234,  1'b0, 5'd3,5'd5, 32'h1234,1'b0,4'd7,  32'h0,1'b0,4'd0,     32'h8};
        vecs[4]  = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd3,5'd0, 32'h1234,1'b0,4'd7,  32'h0,1'b0,4'd0,     32'h0};
        vecs[5]  = '{1'b1,5'd4,4'd2,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd4,5'd0, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd0,     32'h0};
        vecs[6]  = '{1'b1,5'd4,4'd5,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd4,5'd0, 32'h0,1'b1,4'd2,     32'h0,1'b0,4'd0,     32'h10};
        vecs[7]  = '{1'b0,5'd0,4'd0,  1'b1,5'd4,4'd2,32'hAA,    1'b0, 5'd4,5'd4, 32'hAA,1'b1,4'd5,    32'hAA,1'b1,4'd5,    32'h10};
        vecs[8]  = '{1'b0,5'd0,4'd0,  1'b1,5'd4,4'd5,32'hBB,    1'b0, 5'd4,5'd3, 32'hBB,1'b0,4'd5,    32'h1234,1'b0,4'd7,  32'h10};
        vecs[9]  = '{1'b1,5'd6,4'd1,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd4,5'd6, 32'hBB,1'b0,4'd5,    32'h0,1'b0,4'd0,     32'h0};
        vecs[10] = '{1'b1,5'd6,4'd9,  1'b1,5'd6,4'd1,32'h55,    1'b0, 5'd6,5'd6, 32'h55,1'b0,4'd1,    32'h55,1'b0,4'd1,    32'h40};
        vecs[11] = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd6,5'd4, 32'h55,1'b1,4'd9,    32'hBB,1'b0,4'd5,    32'h40};
        vecs[12] = '{1'b1,5'd1,4'd10, 1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd1,5'd0, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd0,     32'h40};
        vecs[13] = '{1'b1,5'd2,4'd11, 1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd1,5'd0, 32'h0,1'b1,4'd10,    32'h0,1'b0,4'd0,     32'h42};
        vecs[14] = '{1'b1,5'd7,4'd12, 1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd2,5'd0, 32'h0,1'b1,4'd11,    32'h0,1'b0,4'd0,     32'h46};
        vecs[15] = '{1'b1,5'd8,4'd3,  1'b1,5'd1,4'd0,32'h77,    1'b1, 5'd1,5'd7, 32'h77,1'b1,4'd10,   32'h0,1'b1,4'd12,    32'hC6};
        vecs[16] = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd8,5'd1, 32'h0,1'b0,4'd0,     32'h77,1'b0,4'd10,   32'h0};
        vecs[17] = '{1'b1,5'd0,4'd4,  1'b1,5'd0,4'd0,32'hFFFF,  1'b0, 5'd0,5'd0, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd0,     32'h0};
        vecs[18] = '{1'b0,5'd0,4'd0,  1'b0,5'd0,4'd0,32'h0,     1'b0, 5'd0,5'd7, 32'h0,1'b0,4'd0,     32'h0,1'b0,4'd12,    32'h0};

        // Reset state while reset is held.
        rst = 1'b0;
        idle_inputs();
        rd_idx = {5'd0, 5'd5};
        model_reset();
        #2;
        chk("reset_val0",  64'(rd_value[31:0]),  64'h0);
        chk("reset_busy0", 64'(rd_busy[0]),      64'h0);
        chk("reset_tag0",  64'(rd_tag[3:0]),     64'h0);
        chk("reset_val1",  64'(rd_value[63:32]), 64'h0);
        chk("reset_busy1", 64'(rd_busy[1]),      64'h0);
        chk("reset_mask",  64'(busy_mask),       64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            iss_valid = vecs[i].iv; iss_rd = vecs[i].ird; iss_tag = vecs[i].itag;
            cm_valid = vecs[i].cv; cm_rd = vecs[i].crd; cm_tag = vecs[i].ctag; cm_value = vecs[i].cval;
            flush = vecs[i].fl;
            rd_idx = {vecs[i].r1, vecs[i].r0};
            @(negedge clk);
            chk($sformatf("v%0d_val0", i),  64'(rd_value[31:0]),  64'(vecs[i].ev0));
            chk($sformatf("v%0d_busy0", i), 64'(rd_busy[0]),      64'(vecs[i].eb0));
            chk($sformatf("v%0d_tag0", i),  64'(rd_tag[3:0]),     64'(vecs[i].et0));
            chk($sformatf("v%0d_val1", i),  64'(rd_value[63:32]), 64'(vecs[i].ev1));
            chk($sformatf("v%0d_busy1", i), 64'(rd_busy[1]),      64'(vecs[i].eb1));
            chk($sformatf("v%0d_tag1", i),  64'(rd_tag[7:4]),     64'(vecs[i].et1));
            chk($sformatf("v%0d_mask", i),  64'(busy_mask),       64'(vecs[i].emask));
            @(posedge clk);
            model_update();
            #1;
        end

        // rdy low: commit, issue and flush are all ignored and bypass is off.
        idle_inputs();
        rdy = 1'b0; flush = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd5; iss_tag = 4'd6;
        cm_valid = 1'b1; cm_rd = 5'd3; cm_tag = 4'd7; cm_value = 32'hDEAD;
        rd_idx = {5'd5, 5'd3};
        @(negedge clk);
        chk("stall_bypass_val", 64'(rd_value[31:0]), 64'h1234);
        @(posedge clk); model_update(); #1;
        idle_inputs();
        @(negedge clk);
        chk("stall_x3_val",  64'(rd_value[31:0]), 64'h1234);
        chk("stall_x3_tag",  64'(rd_tag[3:0]),    64'h7);
        chk("stall_x5_busy", 64'(rd_busy[1]),     64'h0);
        chk("stall_mask",    64'(busy_mask),      64'h0);
        @(posedge clk); model_update(); #1;

        // Asynchronous reset mid-run wipes pending renames and values immediately.
        iss_valid = 1'b1; iss_rd = 5'd9; iss_tag = 4'd2;
        cm_valid = 1'b1; cm_rd = 5'd10; cm_value = 32'h99;
        @(posedge clk); model_update(); #1;
        idle_inputs();
        rd_idx = {5'd9, 5'd10};
        #1;
        chk("prerst_mask",  64'(busy_mask),       64'h200);
        chk("prerst_x10",   64'(rd_value[31:0]),  64'h99);
        rst = 1'b0;
        #1;
        chk("midrst_mask",  64'(busy_mask),       64'h0);
        chk("midrst_x10",   64'(rd_value[31:0]),  64'h0);
        chk("midrst_x9_b",  64'(rd_busy[1]),      64'h0);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = IW'($urandom_range(0, 7));
            iss_tag   = TAG_W'($urandom);
            cm_valid  = 1'($urandom_range(0, 1));
            cm_rd     = IW'($urandom_range(0, 7));
            cm_tag    = ($urandom_range(0, 1) != 0) ? m_tag[cm_rd] : TAG_W'($urandom);
            cm_value  = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            rd_idx    = {IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7))};
            @(negedge clk);
            for (int p = 0; p < int'(NRP); p++) begin
                ix = rd_idx[p*IW +: IW];
                model_read(ix, ev, eb, et);
                chk($sformatf("r%0d_p%0d_val", c, p),  64'(rd_value[p*XLEN +: XLEN]), 64'(ev));
                chk($sformatf("r%0d_p%0d_busy", c, p), 64'(rd_busy[p]),               64'(eb));
                if (eb) chk($sformatf("r%0d_p%0d_tag", c, p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
            end
            chk($sformatf("r%0d_mask", c), 64'(busy_mask), 64'(model_mask()));
            @(posedge clk);
            model_update();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tracking for the Tomasulo/ROB core.
- Sits between decode/issue, the reservation stations and ROB commit.
  - Issue reads source operands as value or ROB tag, and renames the destination to its ROB tag.
  - Commit writes the value back and clears the rename only if the tag still matches.
  - A mispredict flush drops all renames.
- Generalised over data width, register count, tag width and read-port count, with an optional commit-to-read bypass.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two); register 0 is hardwired to zero.
- TAG_W, 4, ROB tag width (ROB depth = 2**TAG_W).
- NRP, 2, number of issue-side read ports.
- BYPASS, 1, 1 = commit value/clear is forwarded to same-cycle reads; 0 = reads see registered state only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, no state changes.
- rd_idx  in  NRP*log2(NREG)  packed source register indices, port p at slice p.
- rd_value  out  NRP*XLEN  register value per port.
- rd_busy  out  NRP  1 = register awaiting ROB result; use rd_tag.
- rd_tag  out  NRP*TAG_W  ROB tag producing the register (valid when rd_busy=1).
- iss_valid  in  1  rename destination this cycle.
- iss_rd  in  log2(NREG)  destination register index.
- iss_tag  in  TAG_W  ROB tag assigned to the issuing instruction.
- cm_valid  in  1  ROB commits a register write this cycle.
- cm_rd  in  log2(NREG)  committed destination index.
- cm_tag  in  TAG_W  ROB tag of the committing entry.
- cm_value  in  XLEN  committed value.
- flush  in  1  mispredict (jump_wrong); clear all renames.
- busy_mask  out  NREG  registered busy bit per register (debug/verification).

Behaviour:
- State per register: value[XLEN], busy, tag[TAG_W].
- Reset (rst=0, asynchronous): all values 0, busy 0, tag 0; busy_mask=0; read outputs therefore show 0/0/0.
- Reads are combinational and independent per port.
  - Index 0 always returns value 0, busy 0, tag 0.
  - BYPASS=1, and cm_valid & rdy & cm_rd==rd_idx!=0:
    - rd_value = cm_value.
    - If busy && tag==cm_tag, rd_busy=0; otherwise busy and tag are unchanged.
  - Reads never reflect the same-cycle iss_* rename, so an instruction's sources are read before its own destination is renamed.
- Updates occur at the rising clk edge only when rdy=1 and rst=1. State written at an edge is visible to non-bypassed reads in the next cycle.
- Commit (cm_valid, cm_rd!=0): value[cm_rd] <= cm_value always.
  - If busy[cm_rd] && tag[cm_rd]==cm_tag, busy <= 0.
  - If the tag does not match (a younger writer is pending), busy and tag are untouched.
- Issue (iss_valid, iss_rd!=0, flush=0): busy[iss_rd] <= 1, tag[iss_rd] <= iss_tag.
- Issue and commit to the same register in the same cycle:
  - The value is written.
  - Issue wins the rename: busy=1, tag=iss_tag, regardless of the commit tag match.
- Flush:
  - All busy bits <= 0 (tags don't-care, hold).
  - A same-cycle commit still writes its value.
  - A same-cycle issue is ignored.
- Writes to register 0 from either issue or commit are discarded.
- rdy=0 freezes all state. Inputs are ignored except the asynchronous reset.
- Reset asserted mid-operation clears state immediately; pending renames are lost.

Decomposition:
- Shared header/package holds XLEN, NREG, the register-index width (log2 NREG), TAG_W, and the zero-register constant, reused by the RS and ROB.
- Sub-module rrf_read_port: one read port including the x0 and bypass logic, instantiated NRP times via generate.

Test Plan:
- Reset, then read x5 and x0 on both ports -> value 0, busy 0, tag 0; busy_mask=0.
- Issue x3 with tag 7. Next cycle read x3 -> busy=1, tag=7. Commit x3 tag 7 value 0x1234 with BYPASS=1 -> same-cycle rd_busy=0, rd_value=0x1234; next cycle busy_mask[3]=0.
- Issue x4 tag 2, then x4 tag 5. Commit x4 tag 2 value 0xAA -> value=0xAA, busy=1, tag=5 remain. Commit tag 5 value 0xBB -> busy=0, value=0xBB.
- Same cycle: issue x6 tag 9 and commit x6 tag 1 value 0x55 (x6 busy with tag 1) -> value=0x55, busy=1, tag=9.
- Rename x1, x2, x7. Pulse flush together with issue x8 tag 3 and commit x1 value 0x77 -> busy_mask all 0, x8 not busy, x1=0x77.
- Issue/commit to x0 with value 0xFFFF -> reads of x0 stay 0/not busy. Hold rdy=0 during a commit -> no state change. Deassert rst mid-run -> all state 0 immediately.
